// File: rtl/fft_feed_ctrl.sv
// Front-end scheduler for the SDF FFT: buffers upstream samples and launches gap-free FRAME_LEN bursts,
// throttled by frames in flight. Define FFT_FEED_STAT_EN to add launch/done/overflow statistics outputs.
module fft_feed_ctrl #(
    parameter int TOTAL_STAGE  = 8,
    parameter int CPLX_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   iclk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [CPLX_WIDTH-1:0]  s_data,
    output logic                   fft_ien,
    output logic [TOTAL_STAGE-1:0] fft_iaddr,
    output logic [CPLX_WIDTH-1:0]  fft_idata,
    input  logic                   fft_oen,
    input  logic [TOTAL_STAGE-1:0] fft_oaddr,
    output logic                   frame_done,
    output logic                   busy,
    output logic [3:0]             inflight
`ifdef FFT_FEED_STAT_EN
    ,
    output logic [15:0]            stat_launched,
    output logic [15:0]            stat_done,
    output logic                   stat_ovf
`endif
);
    localparam int FRAME_LEN = 1 << TOTAL_STAGE;
    localparam int DEPTH     = 2 * FRAME_LEN;
    localparam int AW        = TOTAL_STAGE + 1;
    localparam int PW        = AW + 1;

    localparam logic [PW-1:0]          FRAME_C  = PW'(FRAME_LEN);
    localparam logic [PW-1:0]          DEPTH_C  = PW'(DEPTH);
    localparam logic [3:0]             MAX_C    = 4'(MAX_INFLIGHT);
    localparam logic [TOTAL_STAGE-1:0] LAST_IDX = '1;
    localparam logic [TOTAL_STAGE-1:0] PENULT   = LAST_IDX - TOTAL_STAGE'(1);

    typedef enum logic [1:0] {IDLE, HOLD, STREAM} state_t;

    state_t                 state_q;
    logic [CPLX_WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]          count, count_d;
    logic                   s_ready_q, ien_q, done_q;
    logic [TOTAL_STAGE-1:0] iaddr_q;
    logic [CPLX_WIDTH-1:0]  idata_q;
    logic [3:0]             inflight_q, inflight_d;
    logic                   wr_en, rd_en, launch, comp, frame_avail;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign frame_avail = (count >= FRAME_C) && (inflight_q < MAX_C);
    assign wr_en       = s_valid && s_ready_q && !flush;
    // A completion with nothing in flight is a leftover from a flushed frame.
    assign comp        = fft_oen && (fft_oaddr == LAST_IDX) && (inflight_q != 4'd0) && !flush;

    always_comb begin
        launch = 1'b0;
        rd_en  = 1'b0;
        if (!flush) begin
            case (state_q)
                IDLE, HOLD: begin
                    launch = frame_avail;
                    rd_en  = frame_avail;
                end
                STREAM:  rd_en = 1'b1;
                default: rd_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_d    = count + PW'(wr_en) - PW'(rd_en);
        inflight_d = inflight_q;
        if (launch && !comp) begin
            inflight_d = inflight_q + 4'd1;
        end else if (comp && !launch) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    always_ff @(posedge iclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s_ready_q  <= 1'b0;
            ien_q      <= 1'b0;
            iaddr_q    <= '1;
            idata_q    <= '0;
            inflight_q <= 4'd0;
            done_q     <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s_ready_q  <= 1'b1;
            ien_q      <= 1'b0;
            iaddr_q    <= '1;
            idata_q    <= '0;
            inflight_q <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            s_ready_q  <= (count_d < DEPTH_C);
            inflight_q <= inflight_d;
            done_q     <= comp;
            case (state_q)
                IDLE, HOLD: begin
                    if (launch) begin
                        state_q <= STREAM;
                        ien_q   <= 1'b1;
                        iaddr_q <= '0;
                        idata_q <= mem_q[rd_ptr_q[AW-1:0]];
                    end else begin
                        if (count >= FRAME_C) state_q <= HOLD;
                        ien_q   <= 1'b0;
                        iaddr_q <= '1;
                        idata_q <= '0;
                    end
                end
                STREAM: begin
                    // Returning to IDLE on the last beat lets IDLE launch the next frame with no gap.
                    ien_q   <= 1'b1;
                    iaddr_q <= iaddr_q + TOTAL_STAGE'(1);
                    idata_q <= mem_q[rd_ptr_q[AW-1:0]];
                    if (iaddr_q == PENULT) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ien_q   <= 1'b0;
                    iaddr_q <= '1;
                    idata_q <= '0;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign fft_ien    = ien_q;
    assign fft_iaddr  = iaddr_q;
    assign fft_idata  = idata_q;
    assign frame_done = done_q;
    assign inflight   = inflight_q;
    assign busy       = (state_q != IDLE) || (inflight_q != 4'd0);

`ifdef FFT_FEED_STAT_EN
    logic [15:0] launched_q, done_cnt_q;
    logic [2:0]  ovf_run_q;
    logic        ovf_q;

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            launched_q <= '0;
            done_cnt_q <= '0;
            ovf_run_q  <= '0;
            ovf_q      <= 1'b0;
        end else if (flush) begin
            launched_q <= '0;
            done_cnt_q <= '0;
            ovf_run_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (launch) launched_q <= launched_q + 16'd1;
            if (comp)   done_cnt_q <= done_cnt_q + 16'd1;
            // Run length of refused pushes saturates at 4; the fourth one makes the flag stick.
            if (s_valid && !s_ready_q) begin
                if (ovf_run_q != 3'd4) ovf_run_q <= ovf_run_q + 3'd1;
                if (ovf_run_q >= 3'd3) ovf_q <= 1'b1;
            end else begin
                ovf_run_q <= '0;
            end
        end
    end

    assign stat_launched = launched_q;
    assign stat_done     = done_cnt_q;
    assign stat_ovf      = ovf_q;
`endif

endmodule

// File: doc/fft_feed_ctrl.md
Name: fft_feed_ctrl

Overview:
- Front-end scheduler for the pipelined SDF FFT chain.
- Accepts complex samples from an upstream valid/ready source and buffers them in an internal sample FIFO.
- Launches each frame into the first FFT stage only as one gap-free burst of FRAME_LEN consecutive ien cycles, because a stage mis-sequences if ien drops mid-frame.
- Tracks frames in flight using the last stage's oen/oaddr and throttles launches to MAX_INFLIGHT.

Parameters:
- TOTAL_STAGE, 8, log2 of frame length; FRAME_LEN = 2^TOTAL_STAGE.
- CPLX_WIDTH, 32, complex sample width ({re,im}).
- MAX_INFLIGHT, 4, maximum frames launched but not yet completed (1..15).

Ports:
- iclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO and scheduler
- s_valid  in  1  upstream sample valid
- s_ready  out  1  FIFO can accept a sample
- s_data  in  CPLX_WIDTH  upstream sample
- fft_ien  out  1  first-stage input enable
- fft_iaddr  out  TOTAL_STAGE  first-stage sample index
- fft_idata  out  CPLX_WIDTH  first-stage sample
- fft_oen  in  1  last-stage output enable
- fft_oaddr  in  TOTAL_STAGE  last-stage output index
- frame_done  out  1  one-cycle pulse per completed frame
- busy  out  1  state != IDLE or inflight != 0
- inflight  out  4  frames in flight

Behaviour:
- Reset values: s_ready=0, fft_ien=0, fft_iaddr=all-ones, fft_idata=0, frame_done=0, busy=0, inflight=0. FIFO is empty; state is IDLE.
- Sample FIFO:
  - Depth 2*FRAME_LEN, circular, with pointers one bit wider than the address.
  - s_ready = (count < 2*FRAME_LEN), registered, and deasserts the cycle the FIFO becomes full.
  - A write occurs when s_valid & s_ready.
  - Simultaneous read and write in one cycle: count unchanged.
- State machine:
  - IDLE -> STREAM when count >= FRAME_LEN and inflight < MAX_INFLIGHT. Sampled on the clock edge; the first ien appears on the following cycle.
  - IDLE -> HOLD when count >= FRAME_LEN and inflight == MAX_INFLIGHT.
  - HOLD -> STREAM when inflight < MAX_INFLIGHT.
  - STREAM:
    - Reads one FIFO word per cycle; fft_ien=1.
    - fft_iaddr runs 0..FRAME_LEN-1, and fft_idata is the FIFO word for that index. Both are registered and valid together.
    - After iaddr = FRAME_LEN-1, go to IDLE. Back-to-back frames are allowed, and the next frame's index 0 may follow the previous frame's last index with zero gap.
  - When fft_ien=0, fft_iaddr is held at all-ones and fft_idata at 0.
- Launch accounting: inflight increments on the cycle iaddr==0 is issued.
- Completion: fft_oen & fft_oaddr==all-ones -> frame_done pulses the next cycle and inflight decrements.
- Simultaneous launch and completion in the same cycle: inflight unchanged.
- Completion seen when inflight==0 (stray after flush): ignored, no pulse, no underflow.
- flush:
  - Empties the FIFO, sets the state to IDLE, zeros inflight, and forces fft_ien=0 on the next cycle.
  - If asserted mid-STREAM, the partial frame is abandoned; the downstream stages flush on their own all-ones sequence.
  - Writes in a flush cycle are discarded.
- rst_n deassertion mid-operation is identical to the reset state. No ien is issued until a full frame is buffered again.

Optional Feature:
- Macro FFT_FEED_STAT_EN.
- Defined:
  - Adds outputs stat_launched[15:0] and stat_done[15:0]: wrapping counters of frames launched and frames completed.
  - Adds output stat_ovf, sticky, set when s_valid=1 while s_ready=0 for 4+ consecutive cycles.
  - All three are cleared by rst_n or flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Push 256 samples continuously (TOTAL_STAGE=8) -> fft_ien high for exactly 256 consecutive cycles; iaddr 0..255; idata equals inputs in order; inflight=1.
- Push 512 samples with random s_valid gaps -> two ien bursts, each gap-free with 256 beats, the second starting no earlier than the cycle after the first ends; s_ready drops when the FIFO count reaches 512.
- Model completions: with MAX_INFLIGHT=2, feed 3 frames and hold fft_oen=0 -> only 2 bursts; the third is launched the cycle after one oen & oaddr=255 -> frame_done pulses once and inflight goes 2->1->2.
- Launch of iaddr=0 in the same cycle as a completion -> inflight unchanged; frame_done=1.
- flush at iaddr=100 mid-burst -> fft_ien=0 next cycle, fft_iaddr=all-ones, inflight=0, FIFO empty; a stray completion afterwards gives no frame_done.
- With FFT_FEED_STAT_EN, 3 frames launched and completed -> stat_launched=3, stat_done=3; hold s_valid=1 while full for 4 cycles -> stat_ovf=1 until flush.
